segre_store_drain: RTL and testbench
====================================

// Module: segre_store_drain
// PURPOSE
//  Downstream consumer of segre_store_buffer: takes the oldest store it flushes and writes it into the data cache.
//  Grants the flush slot (flush_chance) only when the cache port is free. Holds one drained store in a register.
//  Places the store into a cache line with byte enables. On a cache write miss, fetches the line from memory and retries.
//  Flags loads that hit the held store, so the pipeline stalls them until the store is visible in the cache.
// PARAMETERS
//  ADDR_SIZE   32  address width (segre_pkg)
//  WORD_SIZE   32  store data width (segre_pkg)
//  LINE_BYTES  16  cache line size in bytes, power of 2 >= 4; LINE_BITS = 8*LINE_BYTES, OFS = $clog2(LINE_BYTES)
// PORTS
//  clk_i            in   1          clock
//  rsn_i            in   1          reset, asynchronous, active-low
//  sb_flush_chance_o out 1          store buffer may flush its tail entry this cycle
//  sb_data_valid_i  in   1          store buffer presents a flushed entry (same cycle as flush_chance)
//  sb_addr_i        in   ADDR_SIZE  flushed store byte address
//  sb_data_i        in   WORD_SIZE  flushed data, right-justified (BYTE in [7:0], HALF in [15:0])
//  sb_type_i        in   memop_data_type_e  BYTE/HALF/WORD
//  load_req_i       in   1          pipeline load owns the cache port this cycle (priority over drain)
//  ld_addr_i        in   ADDR_SIZE  address of that load
//  hold_hit_o       out  1          load word-address matches the held store; pipeline must stall the load
//  dc_wr_req_o      out  1          cache write request
//  dc_wr_addr_o     out  ADDR_SIZE  line-aligned address (low OFS bits 0)
//  dc_wr_be_o       out  LINE_BYTES byte enables
//  dc_wr_data_o     out  LINE_BITS  data shifted into line position
//  dc_wr_ack_i      in   1          same-cycle response to dc_wr_req_o: write done (tag hit)
//  dc_wr_miss_i     in   1          same-cycle response to dc_wr_req_o: tag miss, nothing written
//  mem_rd_req_o     out  1          line fill request; level, held until mem_rd_valid_i
//  mem_rd_addr_o    out  ADDR_SIZE  line-aligned fill address
//  mem_rd_valid_i   in   1          fill done; the cache has installed the line
//  busy_o           out  1          a held store is pending; used by fences
//  miss_cnt_o       out  16         number of drain write misses; saturates at 16'hFFFF
// BEHAVIOUR
//  State machine: IDLE, WRITE, FILL. On reset all outputs are 0 and the held entry is invalid.
//  Reset may assert in any state. It returns the block to IDLE at once and clears the held entry and miss_cnt_o.
//    A mem_rd_valid_i received in IDLE or WRITE is ignored.
//  sb_flush_chance_o = (state==IDLE) & !hold_valid & !load_req_i.
//  Capture: on a clock edge where sb_flush_chance_o & sb_data_valid_i, latch addr/data/type, set hold_valid and go to WRITE.
//    This is one cycle of latency from the flush to the first write request.
//    sb_data_valid_i without sb_flush_chance_o is ignored.
//  WRITE: dc_wr_req_o = !load_req_i; the held store yields whenever a load owns the port, and the state is unchanged.
//    On req & ack: clear hold_valid, go to IDLE. A new flush may be granted the following cycle.
//    On req & miss: increment miss_cnt_o (saturating) and go to FILL.
//    ack and miss both high is illegal; treat it as ack. Neither high keeps the request asserted.
//  FILL: mem_rd_req_o = 1 with mem_rd_addr_o equal to the line address.
//    On mem_rd_valid_i, drop the request and return to WRITE to retry the write. A retry can miss again.
//    dc_wr_req_o is 0 during FILL.
//  Line placement: off = addr[OFS-1:0] aligned down to the access size (BYTE off, HALF off&~1, WORD off&~3).
//    Misaligned low bits are dropped, the same masking the store buffer applies.
//    BYTE sets 1 enable bit, HALF sets 2, WORD sets 4, starting at bit off.
//    dc_wr_data_o = zero-extended data << (8*off); bytes without an enable are 0.
//  hold_hit_o = hold_valid & (held addr[ADDR_SIZE-1:2] == ld_addr_i[ADDR_SIZE-1:2]). It is combinational and ignores load_req_i.
//  busy_o = hold_valid. Outputs dc_wr_* and mem_rd_addr_o are 0 when their request is low.
// TESTING
//  1. Flush WORD 0x1000 data 0xDEADBEEF, ack on the first request
//     -> dc_wr_req_o 1 cycle after capture; be=0x000F, data[31:0]=0xDEADBEEF; back to IDLE.
//  2. Flush BYTE 0x100D data 0xA5 -> addr 0x1000, be=0x2000, data[111:104]=0xA5; HALF 0x1006 0xBEEF -> be=0x00C0.
//  3. WRITE with load_req_i high for 3 cycles -> dc_wr_req_o low for those 3 cycles, flush_chance low, then request and ack.
//  4. Miss on WORD 0x2004 -> FILL, mem_rd_addr_o=0x2000, miss_cnt_o=1; mem_rd_valid_i after 5 cycles -> retry, ack -> IDLE.
//  5. Held store at 0x3008; load at 0x300A -> hold_hit_o=1; load at 0x300C -> 0; after ack -> 0.
//  6. Reset asserted in FILL -> all outputs 0 immediately; a later mem_rd_valid_i does not change state; flush_chance=1.

Source files
------------

// File: rtl/segre_store_drain.sv
// Drains the oldest store-buffer entry into the data cache, one held store at a time,
// refilling the line from memory on a write miss and flagging loads that alias the held store.
package segre_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

module segre_store_drain
  import segre_pkg::*;
#(
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  output logic                    sb_flush_chance_o,
  input  logic                    sb_data_valid_i,
  input  logic [ADDR_SIZE-1:0]    sb_addr_i,
  input  logic [WORD_SIZE-1:0]    sb_data_i,
  input  memop_data_type_e        sb_type_i,
  input  logic                    load_req_i,
  input  logic [ADDR_SIZE-1:0]    ld_addr_i,
  output logic                    hold_hit_o,
  output logic                    dc_wr_req_o,
  output logic [ADDR_SIZE-1:0]    dc_wr_addr_o,
  output logic [LINE_BYTES-1:0]   dc_wr_be_o,
  output logic [8*LINE_BYTES-1:0] dc_wr_data_o,
  input  logic                    dc_wr_ack_i,
  input  logic                    dc_wr_miss_i,
  output logic                    mem_rd_req_o,
  output logic [ADDR_SIZE-1:0]    mem_rd_addr_o,
  input  logic                    mem_rd_valid_i,
  output logic                    busy_o,
  output logic [15:0]             miss_cnt_o
);
  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int OFS       = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    FILL  = 2'b10
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic                 hold_valid_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [WORD_SIZE-1:0] data_r;
  memop_data_type_e     type_r;
  logic [15:0]          miss_cnt_r;

  logic                 capture_s;
  logic                 wr_req_s;
  logic                 mem_req_s;
  logic                 ack_s;
  logic                 miss_s;
  logic [OFS-1:0]       off_s;
  logic [LINE_BYTES-1:0] be_s;
  logic [LINE_BITS-1:0] line_data_s;
  logic [ADDR_SIZE-1:0] line_addr_s;
  logic                 unused_ld_bits_s;

  function automatic logic [LINE_BYTES-1:0] size_be(input memop_data_type_e t);
    case (t)
      BYTE:    size_be = LINE_BYTES'(4'b0001);
      HALF:    size_be = LINE_BYTES'(4'b0011);
      default: size_be = LINE_BYTES'(4'b1111);
    endcase
  endfunction

  // Misaligned low bits are dropped, matching the store buffer's masking.
  function automatic logic [OFS-1:0] align_off(input logic [OFS-1:0] off, input memop_data_type_e t);
    case (t)
      BYTE:    align_off = off;
      HALF:    align_off = off & ~OFS'(1);
      default: align_off = off & ~OFS'(3);
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] size_data(input logic [WORD_SIZE-1:0] d, input memop_data_type_e t);
    case (t)
      BYTE:    size_data = WORD_SIZE'(d[7:0]);
      HALF:    size_data = WORD_SIZE'(d[15:0]);
      default: size_data = d;
    endcase
  endfunction

  assign sb_flush_chance_o = (state_r == IDLE) & ~hold_valid_r & ~load_req_i;
  assign capture_s         = sb_flush_chance_o & sb_data_valid_i;

  // Next state and per-state request/response decode; loads always win the cache port.
  always_comb begin
    state_nxt_s = state_r;
    wr_req_s    = 1'b0;
    mem_req_s   = 1'b0;
    ack_s       = 1'b0;
    miss_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        wr_req_s = ~load_req_i;
        if (wr_req_s & dc_wr_ack_i) begin
          ack_s       = 1'b1;
          state_nxt_s = IDLE;
        end else if (wr_req_s & dc_wr_miss_i) begin
          miss_s      = 1'b1;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      FILL: begin
        mem_req_s = 1'b1;
        if (mem_rd_valid_i) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = FILL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, held store and miss counter.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_r      <= IDLE;
      hold_valid_r <= 1'b0;
      addr_r       <= {ADDR_SIZE{1'b0}};
      data_r       <= {WORD_SIZE{1'b0}};
      type_r       <= BYTE;
      miss_cnt_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        hold_valid_r <= 1'b1;
        addr_r       <= sb_addr_i;
        data_r       <= sb_data_i;
        type_r       <= sb_type_i;
      end else if (ack_s) begin
        hold_valid_r <= 1'b0;
      end
      if (miss_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'h0001;
      end
    end
  end

  assign off_s       = align_off(addr_r[OFS-1:0], type_r);
  assign be_s        = size_be(type_r) << off_s;
  assign line_data_s = LINE_BITS'(size_data(data_r, type_r)) << {off_s, 3'b000};
  assign line_addr_s = {addr_r[ADDR_SIZE-1:OFS], {OFS{1'b0}}};

  assign dc_wr_req_o   = wr_req_s;
  assign dc_wr_addr_o  = wr_req_s ? line_addr_s : {ADDR_SIZE{1'b0}};
  assign dc_wr_be_o    = wr_req_s ? be_s : {LINE_BYTES{1'b0}};
  assign dc_wr_data_o  = wr_req_s ? line_data_s : {LINE_BITS{1'b0}};
  assign mem_rd_req_o  = mem_req_s;
  assign mem_rd_addr_o = mem_req_s ? line_addr_s : {ADDR_SIZE{1'b0}};

  // Word-granular alias check; independent of whether the load currently owns the port.
  assign hold_hit_o       = hold_valid_r & (addr_r[ADDR_SIZE-1:2] == ld_addr_i[ADDR_SIZE-1:2]);
  assign unused_ld_bits_s = ^ld_addr_i[1:0];
  assign busy_o           = hold_valid_r;
  assign miss_cnt_o       = miss_cnt_r;
endmodule

// File: tb/tb_segre_store_drain.sv
// Scoreboard bench for segre_store_drain: directed flushes push expected cache writes and
// line fills; a negedge monitor pops and compares whenever a write is acked or a fill completes.
module tb_segre_store_drain;
  import segre_pkg::*;

  logic             clk = 1'b0;
  logic             rsn;
  logic             flush_chance;
  logic             sb_valid;
  logic [31:0]      sb_addr;
  logic [31:0]      sb_data;
  memop_data_type_e sb_type;
  logic             load_req;
  logic [31:0]      ld_addr;
  logic             hold_hit;
  logic             wr_req;
  logic [31:0]      wr_addr;
  logic [15:0]      wr_be;
  logic [127:0]     wr_data;
  logic             wr_ack;
  logic             wr_miss;
  logic             rd_req;
  logic [31:0]      rd_addr;
  logic             rd_valid;
  logic             busy;
  logic [15:0]      miss_cnt;

  typedef struct {
    logic [31:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] fill_q[$];
  wr_t         mon_e;
  logic [31:0] mon_f;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  segre_store_drain #(.LINE_BYTES(16)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .sb_flush_chance_o(flush_chance), .sb_data_valid_i(sb_valid),
    .sb_addr_i(sb_addr), .sb_data_i(sb_data), .sb_type_i(sb_type),
    .load_req_i(load_req), .ld_addr_i(ld_addr), .hold_hit_o(hold_hit),
    .dc_wr_req_o(wr_req), .dc_wr_addr_o(wr_addr), .dc_wr_be_o(wr_be),
    .dc_wr_data_o(wr_data), .dc_wr_ack_i(wr_ack), .dc_wr_miss_i(wr_miss),
    .mem_rd_req_o(rd_req), .mem_rd_addr_o(rd_addr), .mem_rd_valid_i(rd_valid),
    .busy_o(busy), .miss_cnt_o(miss_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed cache write and every completed fill is checked against the queues.
  always @(negedge clk) begin
    if (rsn && wr_req && wr_ack) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 128'd1, 128'd0);
      end else begin
        mon_e = wr_q.pop_front();
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("wr_be", wr_be, mon_e.be);
        chk("wr_data", wr_data, mon_e.data);
      end
    end
    if (rsn && rd_req && rd_valid) begin
      if (fill_q.size() == 0) begin
        chk("fill_unexpected", 128'd1, 128'd0);
      end else begin
        mon_f = fill_q.pop_front();
        chk("fill_addr", rd_addr, mon_f);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [15:0] be, input logic [127:0] d);
    wr_q.push_back('{addr: a, be: be, data: d});
  endtask

  // Presents one flush in the granted cycle; returns just after the capture edge.
  task automatic flush(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    sb_valid = 1'b1;
    sb_addr  = a;
    sb_data  = d;
    sb_type  = t;
    neg;
    chk("flush_chance_grant", flush_chance, 1'b1);
    chk("req_before_capture", wr_req, 1'b0);
    tick;
    sb_valid = 1'b0;
  endtask

  // Acks the pending write in the current cycle and checks the return to IDLE.
  task automatic ack_now;
    wr_ack = 1'b1;
    neg;
    chk("wr_req_issued", wr_req, 1'b1);
    chk("busy_while_held", busy, 1'b1);
    chk("no_grant_while_held", flush_chance, 1'b0);
    tick;
    wr_ack = 1'b0;
    neg;
    chk("busy_after_ack", busy, 1'b0);
    chk("req_after_ack", wr_req, 1'b0);
    chk("grant_after_ack", flush_chance, 1'b1);
    tick;
  endtask

  initial begin
    rsn = 1'b0; sb_valid = 1'b0; sb_addr = 32'h0; sb_data = 32'h0; sb_type = WORD;
    load_req = 1'b0; ld_addr = 32'h0; wr_ack = 1'b0; wr_miss = 1'b0; rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_wr_data", wr_data, 128'h0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miss_cnt", miss_cnt, 16'h0);
    chk("rst_hold_hit", hold_hit, 1'b0);
    rsn = 1'b1;
    tick;

    // Test 1: word store, acked on the first request
    push_wr(32'h1000, 16'h000F, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    flush(32'h1000, 32'hDEADBEEF, WORD);
    ack_now;

    // Test 2: byte/half placement, upper data bits masked, misaligned low bits dropped
    push_wr(32'h1000, 16'h2000, 128'h0000_A500_0000_0000_0000_0000_0000_0000);
    flush(32'h100D, 32'h1234_56A5, BYTE);
    ack_now;
    push_wr(32'h1000, 16'h00C0, 128'h0000_0000_0000_0000_BEEF_0000_0000_0000);
    flush(32'h1006, 32'h1234_BEEF, HALF);
    ack_now;
    push_wr(32'h1000, 16'h00C0, 128'h0000_0000_0000_0000_1234_0000_0000_0000);
    flush(32'h1007, 32'h0000_1234, HALF);
    ack_now;
    push_wr(32'h1000, 16'hF000, 128'hCAFE_F00D_0000_0000_0000_0000_0000_0000);
    flush(32'h100E, 32'hCAFE_F00D, WORD);
    ack_now;

    // Test 3: loads own the port for 3 cycles
    push_wr(32'h1010, 16'h000F, 128'h0000_0000_0000_0000_0000_0000_1122_3344);
    flush(32'h1010, 32'h1122_3344, WORD);
    load_req = 1'b1;
    ld_addr  = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      neg;
      chk("yield_wr_req", wr_req, 1'b0);
      chk("yield_flush_chance", flush_chance, 1'b0);
      chk("yield_hold_hit", hold_hit, 1'b0);
      tick;
    end
    load_req = 1'b0;
    ack_now;

    // Test 4: write miss, fill, retry
    push_wr(32'h2000, 16'h00F0, 128'h0000_0000_0000_0000_55AA_55AA_0000_0000);
    fill_q.push_back(32'h2000);
    flush(32'h2004, 32'h55AA_55AA, WORD);
    wr_miss = 1'b1;
    neg;
    chk("miss_wr_req", wr_req, 1'b1);
    chk("miss_wr_addr", wr_addr, 32'h2000);
    tick;
    wr_miss = 1'b0;
    neg;
    chk("fill_req", rd_req, 1'b1);
    chk("fill_addr_direct", rd_addr, 32'h2000);
    chk("miss_cnt_1", miss_cnt, 16'h0001);
    chk("fill_no_wr_req", wr_req, 1'b0);
    chk("fill_wr_addr_zero", wr_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      neg;
      chk("fill_req_held", rd_req, 1'b1);
    end
    tick;
    rd_valid = 1'b1;
    neg;
    tick;
    rd_valid = 1'b0;
    neg;
    chk("retry_rd_req_dropped", rd_req, 1'b0);
    chk("retry_wr_req", wr_req, 1'b1);
    chk("retry_rd_addr_zero", rd_addr, 32'h0);
    tick;
    neg;
    chk("retry_wait_req", wr_req, 1'b1);
    tick;
    ack_now;

    // Test 5: load aliasing the held store
    push_wr(32'h3000, 16'h0F00, 128'h0000_0000_0BAD_F00D_0000_0000_0000_0000);
    flush(32'h3008, 32'h0BAD_F00D, WORD);
    load_req = 1'b1;
    ld_addr  = 32'h300A;
    neg;
    chk("hit_same_word", hold_hit, 1'b1);
    chk("hit_wr_req_yield", wr_req, 1'b0);
    tick;
    ld_addr = 32'h300C;
    neg;
    chk("hit_next_word", hold_hit, 1'b0);
    tick;
    load_req = 1'b0;
    ld_addr  = 32'h3009;
    wr_ack   = 1'b1;
    neg;
    chk("hit_no_load_req", hold_hit, 1'b1);
    chk("hit_wr_req", wr_req, 1'b1);
    tick;
    wr_ack  = 1'b0;
    ld_addr = 32'h300A;
    neg;
    chk("hit_after_ack", hold_hit, 1'b0);
    chk("busy_after_hit_ack", busy, 1'b0);
    tick;

    // Test 6: reset during FILL, then a stray fill completion
    flush(32'h4000, 32'h0102_0304, WORD);
    wr_miss = 1'b1;
    neg;
    tick;
    wr_miss = 1'b0;
    ld_addr = 32'h4000;
    neg;
    chk("r6_fill_req", rd_req, 1'b1);
    chk("r6_miss_cnt_2", miss_cnt, 16'h0002);
    tick;
    #2;
    rsn = 1'b0;
    #1;
    chk("r6_rd_req", rd_req, 1'b0);
    chk("r6_rd_addr", rd_addr, 32'h0);
    chk("r6_wr_req", wr_req, 1'b0);
    chk("r6_busy", busy, 1'b0);
    chk("r6_miss_cnt", miss_cnt, 16'h0);
    chk("r6_hold_hit", hold_hit, 1'b0);
    chk("r6_flush_chance", flush_chance, 1'b1);
    neg;
    tick;
    rsn      = 1'b1;
    rd_valid = 1'b1;
    neg;
    chk("r6_stray_valid_rd_req", rd_req, 1'b0);
    chk("r6_stray_valid_wr_req", wr_req, 1'b0);
    tick;
    rd_valid = 1'b0;
    neg;
    chk("r6_idle_busy", busy, 1'b0);
    chk("r6_idle_wr_req", wr_req, 1'b0);
    chk("r6_idle_flush_chance", flush_chance, 1'b1);
    tick;

    push_wr(32'h1000, 16'h000F, 128'h0000_0000_0000_0000_0000_0000_89AB_CDEF);
    flush(32'h1000, 32'h89AB_CDEF, WORD);
    ack_now;

    chk("wr_q_drained", 128'(wr_q.size()), 128'd0);
    chk("fill_q_drained", 128'(fill_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
